// File: rtl/convolution_3x3_if.sv
// convolution_3x3_if: pixel stream, kernel bus and filtered-pixel output of the 3x3 convolution engine
interface convolution_3x3_if #(
    parameter int HWIDTH = 11,
    parameter int VWIDTH = 10
);
    logic                        data_valid_in;
    logic [2:0][15:0]            data_in;
    logic [HWIDTH-1:0]           hcount_in;
    logic [VWIDTH-1:0]           vcount_in;
    logic signed [2:0][2:0][7:0] coeffs;
    logic signed [7:0]           shift;
    logic [15:0]                 line_out;
    logic [HWIDTH-1:0]           hcount_out;
    logic [VWIDTH-1:0]           vcount_out;
    logic                        data_valid_out;

    modport master (
        output data_valid_in, data_in, hcount_in, vcount_in, coeffs, shift,
        input  line_out, hcount_out, vcount_out, data_valid_out
    );

    modport slave (
        input  data_valid_in, data_in, hcount_in, vcount_in, coeffs, shift,
        output line_out, hcount_out, vcount_out, data_valid_out
    );
endinterface

// File: rtl/convolution_3x3.sv
// convolution_3x3: streaming 3x3 RGB565 convolution; define CONV_SATURATE_EN to clamp channels instead of wrapping
module convolution_3x3 #(
    parameter int HWIDTH = 11,
    parameter int VWIDTH = 10
) (
    input logic              clk_in,
    input logic              rst_in,
    convolution_3x3_if.slave bus
);
    logic [2:0][2:0][15:0]       r_win;
    logic signed [2:0][2:0][7:0] r_coef;
    logic signed [7:0]           r_shift;
    logic [3:0]                  r_amt;
    logic [3:0]                  r_valid;
    logic [3:0][HWIDTH-1:0]      r_h;
    logic [3:0][VWIDTH-1:0]      r_v;
    logic signed [14:0]          r_prod [3][3][3];
    logic signed [19:0]          w_acc [3];
    logic [15:0]                 r_line;
    logic [3:0]                  w_amt;
    logic                        w_frame_start;

    assign w_frame_start = bus.data_valid_in && bus.hcount_in == '0 && bus.vcount_in == '0;
    assign w_amt = r_shift[7] ? 4'd0 : (|r_shift[6:4] ? 4'd15 : r_shift[3:0]);

    function automatic logic [6:0] chan(input logic [15:0] p, input int ch);
        return ch == 0 ? {2'b0, p[15:11]} : ch == 1 ? {1'b0, p[10:5]} : {2'b0, p[4:0]};
    endfunction

    // Window shifts in one column per valid cycle; kernel and shift latch only at frame start
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_win   <= '0;
            r_coef  <= '0;
            r_shift <= '0;
        end else begin
            if (bus.data_valid_in) r_win <= {r_win[1], r_win[0], bus.data_in};
            if (w_frame_start) begin
                r_coef  <= bus.coeffs;
                r_shift <= bus.shift;
            end
        end
    end

    // Valid and counts travel alongside the data so bubbles reappear 3 edges later
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= '0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_valid <= {r_valid[2:0], bus.data_valid_in};
            r_h     <= {r_h[2:0], bus.hcount_in};
            r_v     <= {r_v[2:0], bus.vcount_in};
        end
    end

    // Stage 1: signed coeff times zero-extended channel; kernel column 0 meets the oldest column
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_amt <= '0;
            for (int ch = 0; ch < 3; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        r_prod[ch][r][c] <= '0;
        end else begin
            r_amt <= w_amt;
            for (int ch = 0; ch < 3; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        r_prod[ch][r][c] <= 15'($signed(r_coef[r][c])) * 15'($signed(chan(r_win[2-c][r], ch)));
        end
    end

    // Sum of the nine products per channel; 20 bits cannot overflow
    always_comb begin
        for (int ch = 0; ch < 3; ch++) w_acc[ch] = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w_acc[ch] = w_acc[ch] + 20'(r_prod[ch][r][c]);
    end

`ifdef CONV_SATURATE_EN
    logic signed [19:0] r_sum [3];

    function automatic logic [5:0] clamp(input logic signed [19:0] v, input logic g);
        return v[19] ? 6'd0 : (|v[18:6] || (!g && v[5])) ? (g ? 6'd63 : 6'd31) : v[5:0];
    endfunction

    // Stage 2: arithmetic shift of each channel sum
    always_ff @(posedge clk_in) begin
        if (rst_in) for (int ch = 0; ch < 3; ch++) r_sum[ch] <= '0;
        else for (int ch = 0; ch < 3; ch++) r_sum[ch] <= w_acc[ch] >>> r_amt;
    end

    // Stage 3: clamp each channel into its 5/6/5-bit range
    always_ff @(posedge clk_in) begin
        if (rst_in) r_line <= '0;
        else r_line <= {5'(clamp(r_sum[0], 1'b0)), clamp(r_sum[1], 1'b1), 5'(clamp(r_sum[2], 1'b0))};
    end
`else
    logic [15:0] r_sum;

    // Stage 2: arithmetic shift, keeping only the low 5/6/5 bits that the wrap output uses
    always_ff @(posedge clk_in) begin
        if (rst_in) r_sum <= '0;
        else r_sum <= {5'(w_acc[0] >>> r_amt), 6'(w_acc[1] >>> r_amt), 5'(w_acc[2] >>> r_amt)};
    end

    // Stage 3: wrapped pixel onto the output register
    always_ff @(posedge clk_in) begin
        if (rst_in) r_line <= '0;
        else r_line <= r_sum;
    end
`endif

    assign bus.line_out       = r_line;
    assign bus.data_valid_out = r_valid[3];
    assign bus.hcount_out     = r_h[3];
    assign bus.vcount_out     = r_v[3];
endmodule

// File: tb/tb_convolution_3x3.sv
// tb_convolution_3x3: randomized stimulus checked against a behavioural convolution model
module tb_convolution_3x3;
    localparam int HW = 11;
    localparam int VW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    convolution_3x3_if #(.HWIDTH(HW), .VWIDTH(VW)) bus();
    convolution_3x3 #(.HWIDTH(HW), .VWIDTH(VW)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    logic signed [2:0][2:0][7:0] cf;
    logic signed [7:0]           sh;
    int  edge_n = 0;
    int  nvec = 0;
    int  nerr = 0;
    bit  chk_on = 1'b0;

    logic [15:0] m_win [3][3];
    int          m_coef [3][3];
    int          m_shift;
    logic [15:0] exp_line [int];
    int          exp_h [int];
    int          exp_v [int];
    bit          rz [int];
    logic [15:0] lit [int];

`ifdef CONV_SATURATE_EN
    localparam logic [15:0] ONES_EXP = 16'hFFFF;
    localparam logic [15:0] NEG_EXP  = 16'h0000;
`else
    localparam logic [15:0] ONES_EXP = 16'hBEF7;
    localparam logic [15:0] NEG_EXP  = 16'hFFDF;
`endif

    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, edge_n, act, req);
        end
    endtask

    // Convolution from the rules: window column 0 newest, kernel [row][col], clamp shift, wrap or saturate
    function automatic logic [15:0] model_px();
        logic [15:0] res = '0;
        logic [15:0] p;
        int s, sa, mx, v;
        sa = m_shift < 0 ? 0 : (m_shift > 15 ? 15 : m_shift);
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            mx = ch == 1 ? 63 : 31;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    p = m_win[2-c][r];
                    v = ch == 0 ? int'(p[15:11]) : ch == 1 ? int'(p[10:5]) : int'(p[4:0]);
                    s += m_coef[r][c] * v;
                end
            s = s >>> sa;
`ifdef CONV_SATURATE_EN
            s = s < 0 ? 0 : (s > mx ? mx : s);
`else
            s = s & mx;
`endif
            res = (res << (ch == 1 ? 6 : 5)) | 16'(s);
        end
        return res;
    endfunction

    task automatic setk(input int kk[9], input int s);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                cf[r][c] = 8'(kk[r*3+c]);
        sh = 8'(s);
    endtask

    // One clock of stimulus; the model schedules the result for 3 edges after the sampling edge
    task automatic cyc(input bit vld, input logic [15:0] d0, d1, d2, input int h, v,
                       input bit rs, input bit le, input logic [15:0] lv);
        int k;
        @(posedge clk);
        #1;
        rst = rs;
        bus.data_valid_in = vld;
        bus.data_in = {d2, d1, d0};
        bus.hcount_in = HW'(h);
        bus.vcount_in = VW'(v);
        bus.coeffs = cf;
        bus.shift = sh;
        k = edge_n + 1;
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                exp_line.delete(k + i);
                exp_h.delete(k + i);
                exp_v.delete(k + i);
                lit.delete(k + i);
            end
            rz[k] = 1'b1;
            m_win = '{default: '0};
            m_coef = '{default: 0};
            m_shift = 0;
        end else if (vld) begin
            m_win[2] = m_win[1];
            m_win[1] = m_win[0];
            m_win[0] = '{d0, d1, d2};
            if (h == 0 && v == 0) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        m_coef[r][c] = int'($signed(cf[r][c]));
                m_shift = int'(sh);
            end
            exp_line[k+3] = model_px();
            exp_h[k+3] = h;
            exp_v[k+3] = v;
            if (le) lit[k+3] = lv;
        end
    endtask

    task automatic gap();
        cyc(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 1023)), 1'b0, 1'b0, '0);
    endtask

    // Compare the DUT against the model on every cycle after the first reset
    always @(negedge clk) begin
        if (chk_on) begin
            if (rz.exists(edge_n)) begin
                chk("rst_valid", 32'(bus.data_valid_out), 0);
                chk("rst_line", 32'(bus.line_out), 0);
                chk("rst_hcount", 32'(bus.hcount_out), 0);
                chk("rst_vcount", 32'(bus.vcount_out), 0);
            end else if (exp_line.exists(edge_n)) begin
                chk("valid", 32'(bus.data_valid_out), 1);
                chk("line", 32'(bus.line_out), 32'(exp_line[edge_n]));
                chk("hcount", 32'(bus.hcount_out), 32'(exp_h[edge_n]));
                chk("vcount", 32'(bus.vcount_out), 32'(exp_v[edge_n]));
                if (lit.exists(edge_n)) chk("literal", 32'(bus.line_out), 32'(lit[edge_n]));
            end else begin
                chk("idle_valid", 32'(bus.data_valid_out), 0);
            end
        end
    end

    initial begin
        int h, v;
        logic [15:0] base, pm;
        int gk[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int zk[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.data_valid_in = 1'b0;
        bus.data_in = '0;
        bus.hcount_in = '0;
        bus.vcount_in = '0;
        cf = '0;
        sh = '0;
        bus.coeffs = cf;
        bus.shift = sh;
        cyc(1'b0, '0, '0, '0, 0, 0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 0, 0, 1'b1, 1'b0, '0);
        chk_on = 1'b1;

        // Kernel still zero after reset: random pixels give 0x0000 even with a kernel on the bus
        setk(gk, 4);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), i + 5, 2, 1'b0, 1'b1, 16'h0000);

        // Gaussian on flat 0x8410, gaps included
        h = 0; v = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) gap();
            cyc(1'b1, 16'h8410, 16'h8410, 16'h8410, h, v, 1'b0, h >= 2, 16'h8410);
            h++;
            if (h == 16) begin h = 0; v++; end
        end

        // Identity kernel on a ramp: output is the previous column's middle pixel
        setk('{0, 0, 0, 0, 1, 0, 0, 0, 0}, 0);
        base = 16'h0100;
        pm = '0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) gap();
            cyc(1'b1, base - 16'h0421, base, base + 16'h0421, i, 0, 1'b0, i >= 1, pm);
            pm = base;
            base = base + 16'h0843;
        end

        // All ones, shift 0, white input
        setk('{1, 1, 1, 1, 1, 1, 1, 1, 1}, 0);
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, i, 0, 1'b0, i >= 2, ONES_EXP);

        // Centre -1 on 0x0841
        setk('{0, 0, 0, 0, -1, 0, 0, 0, 0}, 0);
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 16'h0841, 16'h0841, 16'h0841, i, 0, 1'b0, i >= 2, NEG_EXP);

        // Mid-frame kernel change is ignored until the next frame start
        setk(gk, 4);
        for (int i = 0; i < 120; i++) begin
            if (i == 100) setk(zk, 0);
            cyc(1'b1, 16'h8410, 16'h8410, 16'h8410, i, 0, 1'b0, i >= 2, 16'h8410);
        end
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 16'h8410, 16'h8410, 16'h8410, i, 0, 1'b0, 1'b1, 16'h0000);

        // Reset with three pixels in flight
        setk(gk, 4);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 16'h8410, 16'h8410, 16'h8410, i, 0, 1'b0, i >= 2, 16'h8410);
        cyc(1'b0, '0, '0, '0, 0, 0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 16'h8410, 16'h8410, 16'h8410, i + 10, 0, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 16'h8410, 16'h8410, 16'h8410, i, 0, 1'b0, i >= 2, 16'h8410);

        // Random kernels, shifts, pixels, gaps, mid-frame changes and occasional resets
        h = 0; v = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                cyc(1'b0, '0, '0, '0, 0, 0, 1'b1, 1'b0, '0);
            end else if ($urandom_range(0, 3) == 0) begin
                gap();
            end else begin
                if ((h == 0 && v == 0) || $urandom_range(0, 9) == 0) begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            cf[r][c] = 8'($urandom_range(0, 255));
                    sh = 8'(int'($urandom_range(0, 45)) - 20);
                end
                cyc(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), h, v, 1'b0, 1'b0, '0);
                h++;
                if (h == 20) begin
                    h = 0;
                    v = (v == 2) ? 0 : v + 1;
                end
            end
        end

        for (int i = 0; i < 6; i++) gap();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
